// File: rtl/p2s_pkg.sv
// Shared types for the p2s_tx serialiser: FSM state encoding and state helpers.
package p2s_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        DONE
    } p2s_state_t;

    function automatic logic is_shift(input p2s_state_t st);
        return (st == SHIFT_LO) || (st == SHIFT_HI);
    endfunction

    function automatic logic is_timed(input p2s_state_t st);
        return (st == SHIFT_LO) || (st == SHIFT_HI) || (st == LATCH);
    endfunction

endpackage

// File: rtl/p2s_tick.sv
// Phase-tick generator: counts DIV cycles while enabled, pulses o_tick on the final count.
module p2s_tick #(
    parameter int DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_tick
);

    localparam int PW = $clog2(DIV + 1);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] r_phase;

    assign o_tick = i_en && (r_phase == LAST);

    // Dropping i_en acts as restart, so every timed state begins from phase 0.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_phase <= '0;
        end else if (!i_en || o_tick) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + PW'(1);
        end
    end

endmodule

// File: rtl/p2s_tx.sv
// Parallel-to-serial transmitter: shifts a WIDTH-bit frame out LSB first with
// a DIV-divided serial clock, then strobes s_lat and pulses done.
module p2s_tx
    import p2s_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done,
    output logic             s_clk,
    output logic             s_dat,
    output logic             s_lat
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    p2s_state_t       r_state;
    p2s_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_buf;
    logic [WIDTH-1:0] w_buf_nxt;
    logic [BW-1:0]    r_bit_cnt;
    logic [BW-1:0]    w_bit_cnt_nxt;
    logic             w_phase_en;
    logic             w_tick;

    assign w_phase_en = is_timed(r_state);

    p2s_tick #(
        .DIV (DIV)
    ) u_tick (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (w_phase_en),
        .o_tick  (w_tick)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_buf_nxt     = r_buf;
        w_bit_cnt_nxt = r_bit_cnt;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_buf_nxt     = data;
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (w_tick) w_state_nxt = SHIFT_HI;
            end
            SHIFT_HI: begin
                if (w_tick) begin
                    w_buf_nxt     = {1'b0, r_buf[WIDTH-1:1]};
                    w_bit_cnt_nxt = r_bit_cnt + BW'(1);
                    w_state_nxt   = (r_bit_cnt == LAST_BIT) ? LATCH : SHIFT_LO;
                end
            end
            LATCH: begin
                if (w_tick) w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they line up with
    // r_state while still having no combinational path from the inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_buf     <= '0;
            r_bit_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            s_clk     <= 1'b0;
            s_dat     <= 1'b0;
            s_lat     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_buf     <= w_buf_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            busy      <= (w_state_nxt != IDLE);
            done      <= (w_state_nxt == DONE);
            s_clk     <= (w_state_nxt == SHIFT_HI);
            s_lat     <= (w_state_nxt == LATCH);
            s_dat     <= is_shift(w_state_nxt) ? w_buf_nxt[0] : 1'b0;
        end
    end

endmodule

// File: tb/tb_p2s_tx.sv
// Self-checking bench for p2s_tx: WIDTH=8 with DIV=2 and DIV=1 instances,
// outputs compared cycle by cycle against an arithmetic waveform model.
module tb_p2s_tx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start2, start1;
    logic [W-1:0] data2, data1;
    logic         busy2, done2, sclk2, sdat2, slat2;
    logic         busy1, done1, sclk1, sdat1, slat1;
    logic [4:0]   obs2, obs1;
    int           total = 0;
    int           bad = 0;

    always #5 clk = ~clk;

    assign obs2 = {busy2, done2, sclk2, sdat2, slat2};
    assign obs1 = {busy1, done1, sclk1, sdat1, slat1};

    p2s_tx #(.WIDTH(W), .DIV(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .data(data2),
        .busy(busy2), .done(done2), .s_clk(sclk2), .s_dat(sdat2), .s_lat(slat2)
    );

    p2s_tx #(.WIDTH(W), .DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .data(data1),
        .busy(busy1), .done(done1), .s_clk(sclk1), .s_dat(sdat1), .s_lat(slat1)
    );

    // Expected {busy,done,s_clk,s_dat,s_lat} k cycles after the accepting edge
    // (k=1 is the first sample after that edge).
    function automatic logic [4:0] model(input logic [W-1:0] d, input int k, input int dv);
        int sh;
        logic [4:0] m;
        sh = 2 * dv * W;
        m  = '0;
        if (k >= 1 && k <= sh + dv + 1) m[4] = 1'b1;
        if (k == sh + dv + 1)           m[3] = 1'b1;
        if (k >= 1 && k <= sh) begin
            m[2] = (((k - 1) / dv) % 2) == 1;
            m[1] = d[(k - 1) / (2 * dv)];
        end
        if (k > sh && k <= sh + dv)     m[0] = 1'b1;
        return m;
    endfunction

    task automatic test_reset();
        rst_n  = 1'b0;
        start2 = 1'b1;
        start1 = 1'b1;
        data2  = W'($urandom);
        data1  = W'($urandom);
        repeat (3) @(negedge clk);
        total++;
        if (obs2 !== 5'b0) begin bad++; $display("FAIL reset_div2 got=%b exp=%b", obs2, 5'b0); end
        total++;
        if (obs1 !== 5'b0) begin bad++; $display("FAIL reset_div1 got=%b exp=%b", obs1, 5'b0); end
        start2 = 1'b0;
        start1 = 1'b0;
        rst_n  = 1'b1;
        @(negedge clk);
        total++;
        if (obs2 !== 5'b0) begin bad++; $display("FAIL reset_release got=%b exp=%b", obs2, 5'b0); end
    endtask

    task automatic test_single();
        logic [W-1:0] got;
        logic [4:0]   e;
        int edges, lat, done_k;
        logic prev;
        got = '0; edges = 0; lat = 0; done_k = -1; prev = 1'b0;
        data2  = 8'hA5;
        start2 = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start2 = 1'b0;
            e = model(8'hA5, k, 2);
            total++;
            if (obs2 !== e) begin bad++; $display("FAIL single_wave k=%0d got=%b exp=%b", k, obs2, e); end
            if (sclk2 && !prev) begin
                if (edges < W) got[edges] = sdat2;
                edges++;
            end
            prev = sclk2;
            if (slat2) lat++;
            if (done2) done_k = k;
        end
        total++;
        if (edges != 8) begin bad++; $display("FAIL single_edges got=%0d exp=8", edges); end
        total++;
        if (got !== 8'hA5) begin bad++; $display("FAIL single_bits got=%h exp=a5", got); end
        total++;
        if (lat != 2) begin bad++; $display("FAIL single_lat got=%0d exp=2", lat); end
        total++;
        if (done_k != 35) begin bad++; $display("FAIL single_latency got=%0d exp=35", done_k); end
    endtask

    task automatic test_busy_reject();
        logic [4:0] e;
        int dones;
        dones  = 0;
        data2  = 8'h0F;
        start2 = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            e = model(8'h0F, k, 2);
            total++;
            if (obs2 !== e) begin bad++; $display("FAIL reject_wave k=%0d got=%b exp=%b", k, obs2, e); end
            if (done2) dones++;
            start2 = (k == 5);
            if (k == 5) data2 = 8'hFF;
        end
        total++;
        if (dones != 1) begin bad++; $display("FAIL reject_dones got=%0d exp=1", dones); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] e;
        int d_first, d_second, edges_a, edges_b;
        logic prev;
        d_first = -1; d_second = -1; edges_a = 0; edges_b = 0; prev = 1'b0;
        data2  = 8'h01;
        start2 = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            e = (k <= 36) ? model(8'h01, k, 2) : model(8'h01, k - 36, 2);
            total++;
            if (obs2 !== e) begin bad++; $display("FAIL b2b_wave k=%0d got=%b exp=%b", k, obs2, e); end
            if (sclk2 && !prev) begin
                if (k <= 36) edges_a++; else edges_b++;
            end
            prev = sclk2;
            if (done2) begin
                if (d_first < 0) d_first = k; else d_second = k;
            end
            if (k == 40) start2 = 1'b0;
        end
        total++;
        if (d_second - d_first != 36) begin
            bad++; $display("FAIL b2b_spacing got=%0d exp=36", d_second - d_first);
        end
        total++;
        if (edges_a != 8 || edges_b != 8) begin
            bad++; $display("FAIL b2b_edges got=%0d/%0d exp=8/8", edges_a, edges_b);
        end
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] d;
        logic [4:0]   e;
        d      = W'($urandom);
        data2  = d;
        start2 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start2 = 1'b0;
            e = model(d, k, 2);
            total++;
            if (obs2 !== e) begin bad++; $display("FAIL midrst_pre k=%0d got=%b exp=%b", k, obs2, e); end
        end
        rst_n  = 1'b0;
        start2 = 1'b1;
        @(negedge clk);
        total++;
        if (obs2 !== 5'b0) begin bad++; $display("FAIL midrst_outputs got=%b exp=%b", obs2, 5'b0); end
        rst_n  = 1'b1;
        start2 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            total++;
            if (obs2 !== 5'b0) begin bad++; $display("FAIL midrst_quiet k=%0d got=%b exp=%b", k, obs2, 5'b0); end
        end
        data2  = 8'h3C;
        start2 = 1'b1;
        for (int k = 1; k <= 38; k++) begin
            @(negedge clk);
            start2 = 1'b0;
            e = model(8'h3C, k, 2);
            total++;
            if (obs2 !== e) begin bad++; $display("FAIL midrst_post k=%0d got=%b exp=%b", k, obs2, e); end
        end
    endtask

    task automatic test_div1();
        logic [4:0] e;
        logic [W-1:0] d;
        int edges, toggles, done_k;
        logic prev;
        for (int f = 0; f < 3; f++) begin
            d = (f == 0) ? 8'hFF : W'($urandom);
            edges = 0; toggles = 0; done_k = -1; prev = 1'b0;
            data1  = d;
            start1 = 1'b1;
            for (int k = 1; k <= 22; k++) begin
                @(negedge clk);
                start1 = 1'b0;
                e = model(d, k, 1);
                total++;
                if (obs1 !== e) begin bad++; $display("FAIL div1_wave f=%0d k=%0d got=%b exp=%b", f, k, obs1, e); end
                if (sclk1 && !prev) edges++;
                if (k >= 2 && k <= 16 && sclk1 != prev) toggles++;
                prev = sclk1;
                if (done1) done_k = k;
            end
            total++;
            if (edges != 8 || toggles != 15) begin
                bad++; $display("FAIL div1_sclk f=%0d got=%0d/%0d exp=8/15", f, edges, toggles);
            end
            total++;
            if (done_k != 18) begin bad++; $display("FAIL div1_latency f=%0d got=%0d exp=18", f, done_k); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] d;
        logic [4:0]   e;
        for (int f = 0; f < 6; f++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            d      = W'($urandom);
            data2  = d;
            start2 = 1'b1;
            for (int k = 1; k <= 37; k++) begin
                @(negedge clk);
                e = model(d, k, 2);
                total++;
                if (obs2 !== e) begin bad++; $display("FAIL random_wave f=%0d k=%0d got=%b exp=%b", f, k, obs2, e); end
                start2 = (k < 30) ? 1'($urandom_range(0, 1)) : 1'b0;
                data2  = W'($urandom);
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start2 = 1'b0;
        start1 = 1'b0;
        data2  = '0;
        data1  = '0;
        test_reset();
        test_single();
        test_busy_reject();
        test_back_to_back();
        test_mid_reset();
        test_div1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/p2s_tx.md
P2S_TX -- requirements
Module: p2s_tx

Interface
REQ-001 SHALL provide parameter WIDTH, default 64, giving the number of bits serialised per frame (legal: 2..64).
REQ-002 SHALL provide parameter DIV, default 4, giving clk cycles per s_clk half-period (legal: 1..255).
REQ-003 SHALL use one clock and a synchronous, active-low reset: clk, rst_n.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 start  input  1  request to send one frame; sampled only when busy=0.
REQ-007 data  input  WIDTH  frame to send; captured on the accepted start cycle.
REQ-008 busy  output  1  high from the cycle after start acceptance until done.
REQ-009 done  output  1  one-cycle pulse at frame end.
REQ-010 s_clk  output  1  serial clock to the downstream shift register; idle low.
REQ-011 s_dat  output  1  serial data, LSB first; valid before and across every s_clk rising edge.
REQ-012 s_lat  output  1  latch strobe after the last bit; idle low.

Function
REQ-013 SHALL implement the FSM IDLE -> SHIFT_LO -> SHIFT_HI -> (SHIFT_LO | LATCH) -> DONE -> IDLE.
REQ-014 IDLE: outputs s_clk=0, s_lat=0, busy=0, done=0; start=1 captures data into the internal buffer, clears the bit counter and enters SHIFT_LO.
REQ-015 SHIFT_LO: s_clk=0 and s_dat=buffer[0], held for DIV cycles, then enter SHIFT_HI.
REQ-016 SHIFT_HI: s_clk=1 and s_dat unchanged for DIV cycles; on exit, right-shift the buffer (0 into MSB) and increment the bit counter.
REQ-017 On SHIFT_HI exit, SHALL go to LATCH when the bit counter reaches WIDTH-1 before increment, else to SHIFT_LO.
REQ-018 LATCH: s_clk=0 and s_lat=1 for DIV cycles, then enter DONE.
REQ-019 DONE: done=1 and busy=1 for exactly one cycle, then return to IDLE.
REQ-020 Frame latency from the accepted start edge to the done pulse SHALL be exactly 2*DIV*WIDTH + DIV + 1 cycles.
REQ-021 start while busy=1 SHALL be ignored, and data changes after capture SHALL NOT affect the frame.
REQ-022 start held high SHALL begin a new frame on the first IDLE cycle after DONE (back-to-back frames, one idle cycle between).
REQ-023 DIV=1 SHALL yield s_clk = clk/2 with no skipped or doubled edges.
REQ-024 The phase counter SHALL be $clog2(DIV+1) bits and the bit counter $clog2(WIDTH+1) bits, with no wrap within a frame.
REQ-025 s_dat SHALL be 0 whenever the FSM is not in SHIFT_LO or SHIFT_HI.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE, clear the buffer and counters, and drive busy=0, done=0, s_clk=0, s_dat=0, s_lat=0 from that edge on.
REQ-027 Reset mid-frame SHALL abort without a done pulse or s_lat pulse; start is ignored while rst_n=0.

Structure
REQ-028 SHALL place the FSM state enum (IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE) in shared package p2s_pkg.
REQ-029 SHALL place the phase-tick generator (a DIV-cycle counter that outputs tick on its final count and reloads on restart) in one sub-module, p2s_tick.
REQ-030 All outputs SHALL be registered, with no combinational path from start or data to any output.

Verification (bench parameters WIDTH=8, DIV=2)
REQ-031 Single frame: data=8'hA5, start pulsed -> s_dat samples at the 8 s_clk rising edges read 1,0,1,0,0,1,0,1; s_lat high 2 cycles; done exactly 35 cycles after acceptance.
REQ-032 Busy rejection: start with 8'h0F, then start with 8'hFF at cycle 5 -> only 8'h0F is sent, with exactly one done pulse.
REQ-033 Back-to-back: start held high with data=8'h01 -> two frames, done pulses 36 cycles apart, 8 s_clk rising edges per frame.
REQ-034 Mid-frame reset: rst_n=0 for 1 cycle at cycle 10 -> next cycle all outputs 0, busy=0, no done; a following start with 8'h3C sends cleanly.
REQ-035 DIV=1 rerun: data=8'hFF -> s_clk toggles every cycle, 8 rising edges with s_dat=1, done 18 cycles after acceptance.
